inmp441_style_i2s_transmitter: RTL and testbench

- I2S master transmitter that drives a 24-bit stereo I2S DAC/amplifier (PCM5102/MAX98357-class) from parallel samples.
- Generates its own bit clock (sck), word select (ws) and serial data (sd) by dividing clk.
- Frame timing matches the microphone receiver path, so capture and playback share one sample rate (50 MHz / 1024 ≈ 48.8 kHz).
- Upstream logic supplies one left/right pair per frame through a valid/ready handshake into a one-entry holding buffer.

---
 rtl/inmp441_style_i2s_transmitter.sv | 128 ++++++++++++
 tb/tb_inmp441_style_i2s_transmitter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inmp441_style_i2s_transmitter.sv
// I2S master transmitter: divides clk into sck/ws and serializes one buffered
// left/right sample pair per frame, MSB first, one sck after each ws edge.
module inmp441_style_i2s_transmitter #(
    parameter int unsigned SCK_DIV_LOG2 = 3,
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned SLOT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] in_left,
    input  logic [SAMPLE_WIDTH-1:0] in_right,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    sck,
    output logic                    ws,
    output logic                    sd,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int unsigned SlotLog2 = $clog2(SLOT_WIDTH);
    localparam int unsigned PosWidth = SlotLog2 + 1;
    localparam int unsigned CntWidth = SCK_DIV_LOG2 + 1 + PosWidth;
    localparam int unsigned IdxWidth = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    ws_q, ws_d;
    logic                    sd_q, sd_d;
    logic                    full_q, full_d;
    logic [SAMPLE_WIDTH-1:0] buf_left_q, buf_left_d;
    logic [SAMPLE_WIDTH-1:0] buf_right_q, buf_right_d;
    logic [SAMPLE_WIDTH-1:0] tx_left_q, tx_left_d;
    logic [SAMPLE_WIDTH-1:0] tx_right_q, tx_right_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;

    logic                    bit_edge;
    logic                    frame_edge;
    logic                    accept;
    logic [PosWidth-1:0]     pos_next;
    logic [SlotLog2-1:0]     offset;
    logic [SAMPLE_WIDTH-1:0] slot_sample;
    logic [IdxWidth-1:0]     bit_idx;
    logic                    in_range;

    always_comb begin
        cnt_d      = cnt_q + CntWidth'(1);
        bit_edge   = &cnt_q[SCK_DIV_LOG2:0];
        frame_edge = &cnt_q;
        accept     = in_valid & ~full_q;

        // ws/sd are computed for the bit position that starts after this edge
        pos_next    = cnt_d[CntWidth-1 -: PosWidth];
        offset      = pos_next[SlotLog2-1:0];
        slot_sample = pos_next[SlotLog2] ? tx_right_q : tx_left_q;
        in_range    = (offset != '0) && (32'(offset) <= SAMPLE_WIDTH);
        bit_idx     = IdxWidth'(SAMPLE_WIDTH - 32'(offset));

        ws_d = ws_q;
        sd_d = sd_q;
        if (bit_edge) begin
            ws_d = pos_next[SlotLog2];
            sd_d = in_range & slot_sample[bit_idx];
        end

        full_d        = full_q;
        buf_left_d    = buf_left_q;
        buf_right_d   = buf_right_q;
        tx_left_d     = tx_left_q;
        tx_right_d    = tx_right_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (frame_edge) begin
            frame_start_d = 1'b1;
            if (full_q) begin
                tx_left_d  = buf_left_q;
                tx_right_d = buf_right_q;
                full_d     = 1'b0;
            end else begin
                tx_left_d  = '0;
                tx_right_d = '0;
                underrun_d = 1'b1;
            end
        end

        // Only possible when the buffer was empty, so a same-edge load already saw silence
        if (accept) begin
            full_d      = 1'b1;
            buf_left_d  = in_left;
            buf_right_d = in_right;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            ws_q          <= 1'b0;
            sd_q          <= 1'b0;
            full_q        <= 1'b0;
            buf_left_q    <= '0;
            buf_right_q   <= '0;
            tx_left_q     <= '0;
            tx_right_q    <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            full_q        <= full_d;
            buf_left_q    <= buf_left_d;
            buf_right_q   <= buf_right_d;
            tx_left_q     <= tx_left_d;
            tx_right_q    <= tx_right_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sck         = cnt_q[SCK_DIV_LOG2];
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign in_ready    = ~full_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_inmp441_style_i2s_transmitter.sv
// Directed self-checking bench for the I2S transmitter at default parameters.
module tb_inmp441_style_i2s_transmitter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] in_left = '0;
    logic [23:0] in_right = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, sck, ws, sd, frame_start, underrun;

    int n_cmp = 0;
    int n_err = 0;

    inmp441_style_i2s_transmitter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_left    (in_left),
        .in_right   (in_right),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sck        (sck),
        .ws         (ws),
        .sd         (sd),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Expected sd per bit position: left MSB at p=1, right MSB at p=33, rest zero
    function automatic logic [63:0] exp_sd(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] v;
        v = '0;
        for (int p = 1; p <= 24; p++) begin
            v[p]      = l[24-p];
            v[32 + p] = r[24-p];
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_ws();
        logic [63:0] v;
        for (int p = 0; p < 64; p++) v[p] = (p >= 32);
        return v;
    endfunction

    // Leaves the bench at a negedge with reset just released and cnt=0
    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_fs(input int limit, output int waited);
        waited = 0;
        while (frame_start !== 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Samples sd/ws while sck is high in each of the 64 bit positions of one frame
    task automatic capture(output logic [63:0] sdb, output logic [63:0] wsb, output logic got,
                           output logic ur, output logic ur_after, output logic sck_ok);
        int w;
        wait_fs(2100, w);
        got    = (frame_start === 1'b1);
        ur     = underrun;
        sck_ok = 1'b1;
        @(negedge clk);
        ur_after = underrun;
        repeat (7) @(negedge clk);
        for (int p = 0; p < 64; p++) begin
            if (p > 0) repeat (16) @(negedge clk);
            sdb[p] = sd;
            wsb[p] = ws;
            if (sck !== 1'b1) sck_ok = 1'b0;
        end
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int bad_pulse = 0, bad_sd = 0, bad_sck = 0;
        do_reset();
        n_cmp++;
        if ({sck, ws, sd, in_ready, frame_start, underrun} !== 6'b000100) begin
            n_err++;
            $display("FAIL reset_state: got %b want 000100",
                     {sck, ws, sd, in_ready, frame_start, underrun});
        end
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (sck !== 1'((k >> 3) & 1)) bad_sck++;
            if (sd !== 1'b0) bad_sd++;
            if (k < 1024 && (frame_start !== 1'b0 || underrun !== 1'b0)) bad_pulse++;
            if (k == 511) begin
                n_cmp++;
                if (ws !== 1'b0) begin n_err++; $display("FAIL ws_before_512: got %b want 0", ws); end
            end
            if (k == 512) begin
                n_cmp++;
                if (ws !== 1'b1) begin n_err++; $display("FAIL ws_rise_512: got %b want 1", ws); end
            end
            if (k == 1024) begin
                n_cmp++;
                if ({frame_start, underrun} !== 2'b11) begin
                    n_err++;
                    $display("FAIL first_wrap_pulses: got %b want 11", {frame_start, underrun});
                end
            end
        end
        n_cmp++;
        if (bad_sck != 0) begin n_err++; $display("FAIL sck_divide: got %0d bad want 0", bad_sck); end
        n_cmp++;
        if (bad_sd != 0) begin n_err++; $display("FAIL sd_silent: got %0d bad want 0", bad_sd); end
        n_cmp++;
        if (bad_pulse != 0) begin
            n_err++;
            $display("FAIL early_pulse: got %0d bad want 0", bad_pulse);
        end
        @(negedge clk);
        n_cmp++;
        if ({frame_start, underrun} !== 2'b00) begin
            n_err++;
            $display("FAIL pulse_width: got %b want 00", {frame_start, underrun});
        end
    endtask

    task automatic test_single_pair();
        logic [63:0] sdb, wsb;
        logic got, ur, ura, sok;
        do_reset();
        push(24'hA5A5A5, 24'h123456);
        in_left  = 24'hFFFFFF;
        in_right = 24'hFFFFFF;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_after_accept: got %b want 0", in_ready); end
        capture(sdb, wsb, got, ur, ura, sok);
        n_cmp++;
        if ({got, ur, sok} !== 3'b101) begin
            n_err++;
            $display("FAIL single_frame_flags: got %b want 101", {got, ur, sok});
        end
        n_cmp++;
        if (sdb !== exp_sd(24'hA5A5A5, 24'h123456)) begin
            n_err++;
            $display("FAIL single_sd: got %h want %h", sdb, exp_sd(24'hA5A5A5, 24'h123456));
        end
        n_cmp++;
        if (wsb !== exp_ws()) begin n_err++; $display("FAIL single_ws: got %h want %h", wsb, exp_ws()); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_load: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] bl[3], br[3];
        logic [63:0] sdb[3], wsb[3];
        logic got[3], ur[3], ura[3], sok[3];
        int low[3];
        bl = '{24'h800001, 24'h7FFFFE, 24'h0F0F0F};
        br = '{24'h000001, 24'hC3C3C3, 24'hFFFFFF};
        do_reset();
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int w;
                    in_left  = bl[i];
                    in_right = br[i];
                    in_valid = 1'b1;
                    w = 0;
                    while (in_ready !== 1'b1 && w < 3000) begin @(negedge clk); w++; end
                    @(negedge clk);
                    low[i] = 0;
                    while (in_ready !== 1'b1 && low[i] < 3000) begin low[i]++; @(negedge clk); end
                end
                in_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 3; f++) capture(sdb[f], wsb[f], got[f], ur[f], ura[f], sok[f]);
            end
        join
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (low[i] != 1023) begin
                n_err++;
                $display("FAIL b2b_ready_low[%0d]: got %0d want 1023", i, low[i]);
            end
            n_cmp++;
            if ({got[i], ur[i], sok[i]} !== 3'b101) begin
                n_err++;
                $display("FAIL b2b_flags[%0d]: got %b want 101", i, {got[i], ur[i], sok[i]});
            end
            n_cmp++;
            if (sdb[i] !== exp_sd(bl[i], br[i])) begin
                n_err++;
                $display("FAIL b2b_sd[%0d]: got %h want %h", i, sdb[i], exp_sd(bl[i], br[i]));
            end
        end
    endtask

    task automatic test_starve();
        logic [63:0] sdb, wsb;
        logic got, ur, ura, sok;
        do_reset();
        push(24'h5A5A5A, 24'hABCDEF);
        capture(sdb, wsb, got, ur, ura, sok);
        n_cmp++;
        if ({got, ur} !== 2'b10 || sdb !== exp_sd(24'h5A5A5A, 24'hABCDEF)) begin
            n_err++;
            $display("FAIL starve_first: got %b/%h want 10/%h", {got, ur}, sdb,
                     exp_sd(24'h5A5A5A, 24'hABCDEF));
        end
        for (int f = 0; f < 2; f++) begin
            capture(sdb, wsb, got, ur, ura, sok);
            n_cmp++;
            if ({got, ur, ura, sok} !== 4'b1101) begin
                n_err++;
                $display("FAIL starve_flags[%0d]: got %b want 1101", f, {got, ur, ura, sok});
            end
            n_cmp++;
            if (sdb !== 64'h0 || wsb !== exp_ws()) begin
                n_err++;
                $display("FAIL starve_data[%0d]: got %h/%h want 0/%h", f, sdb, wsb, exp_ws());
            end
        end
    endtask

    task automatic test_wrap_edge();
        logic [63:0] sdb, wsb;
        logic got, ur, ura, sok;
        do_reset();
        repeat (1023) @(negedge clk);
        push(24'hC0FFEE, 24'h00BEEF);
        n_cmp++;
        if ({frame_start, underrun, in_ready} !== 3'b110) begin
            n_err++;
            $display("FAIL wrap_accept: got %b want 110", {frame_start, underrun, in_ready});
        end
        capture(sdb, wsb, got, ur, ura, sok);
        n_cmp++;
        if ({got, ur} !== 2'b11 || sdb !== 64'h0) begin
            n_err++;
            $display("FAIL wrap_silent: got %b/%h want 11/0", {got, ur}, sdb);
        end
        repeat (7) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL wrap_ready_held: got %b want 0", in_ready); end
        capture(sdb, wsb, got, ur, ura, sok);
        n_cmp++;
        if ({got, ur, in_ready} !== 3'b101 || sdb !== exp_sd(24'hC0FFEE, 24'h00BEEF)) begin
            n_err++;
            $display("FAIL wrap_play: got %b/%h want 101/%h", {got, ur, in_ready}, sdb,
                     exp_sd(24'hC0FFEE, 24'h00BEEF));
        end
    endtask

    task automatic test_mid_reset();
        int w;
        do_reset();
        push(24'h111111, 24'h222222);
        wait_fs(2100, w);
        push(24'h333333, 24'h444444);
        repeat (644) @(negedge clk);
        n_cmp++;
        if ({ws, in_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL pre_reset_state: got %b want 10", {ws, in_ready});
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({sck, ws, sd, in_ready, frame_start, underrun} !== 6'b000100) begin
            n_err++;
            $display("FAIL mid_reset_state: got %b want 000100",
                     {sck, ws, sd, in_ready, frame_start, underrun});
        end
        reset_n = 1'b1;
        wait_fs(2100, w);
        n_cmp++;
        if (w != 1024 || underrun !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_restart: got %0d/%b want 1024/1", w, underrun);
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_starve();
        test_wrap_edge();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
